// File: rtl/util_collector_fifo.sv
// ============================================================================
//  Module   : util_collector_fifo
//  Purpose  : Width-collecting synchronous FIFO. Accepts WRITE_WIDTH-bit words
//             and presents READ_SCALE consecutive words packed into a single
//             WRITE_WIDTH*READ_SCALE-bit read word (first-word-fall-through).
//             Oldest write word sits in the LSBs of the read word.
//  Ports    : clk       rising-edge clock
//             rst_n     asynchronous reset, active-high (1 = reset)
//             wr_en     write request, accepted when full=0
//             din       write data
//             full      no room for one more write word
//             rd_en     read request, accepted when empty=0
//             empty     fewer than READ_SCALE words stored
//             dout      packed read data, forced to 0 while empty
//             overflow  (option) sticky: write attempted while full
//             underflow (option) sticky: read attempted while empty
//             level     (option) occupancy in write words
//  Options  : define COLLECT_FIFO_STATUS_EN to add overflow/underflow/level.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module util_collector_fifo #(
  parameter int WRITE_WIDTH = 32,
  parameter int READ_SCALE  = 2,
  parameter int DEPTH       = 16
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                wr_en,
  output logic                                full,
  input  logic [WRITE_WIDTH-1:0]              din,
  input  logic                                rd_en,
  output logic                                empty,
  output logic [WRITE_WIDTH*READ_SCALE-1:0]   dout
`ifdef COLLECT_FIFO_STATUS_EN
  ,
  output logic                                overflow,
  output logic                                underflow,
  output logic [$clog2(DEPTH*READ_SCALE):0]   level
`endif
);

  localparam int SLOTS = DEPTH * READ_SCALE;
  localparam int AW    = $clog2(SLOTS);
  localparam int CW    = AW + 1;

  localparam logic [CW-1:0] c_slots     = CW'(SLOTS);
  localparam logic [CW-1:0] c_scale_cnt = CW'(READ_SCALE);
  localparam logic [AW-1:0] c_last_wr   = AW'(SLOTS - 1);
  localparam logic [AW-1:0] c_last_rd   = AW'(SLOTS - READ_SCALE);
  localparam logic [AW-1:0] c_scale_ptr = AW'(READ_SCALE);

  logic [WRITE_WIDTH-1:0]            r_mem [SLOTS];
  logic [AW-1:0]                     r_wr_ptr;
  logic [AW-1:0]                     r_rd_ptr;
  logic [CW-1:0]                     r_cnt;

  logic                              w_full;
  logic                              w_empty;
  logic                              w_wr_acc;
  logic                              w_rd_acc;
  logic [WRITE_WIDTH*READ_SCALE-1:0] w_group;

  // Status is a pure function of the registered count, so it moves one cycle
  // after the accepting edge and a same-cycle read cannot unblock a write.
  assign w_full   = (r_cnt == c_slots);
  assign w_empty  = (r_cnt < c_scale_cnt);
  assign w_wr_acc = wr_en & ~w_full;
  assign w_rd_acc = rd_en & ~w_empty;

  assign full  = w_full;
  assign empty = w_empty;

  // Storage is not reset; stale contents are hidden by empty/dout gating.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  // Pointers wrap explicitly so non-power-of-two READ_SCALE still works.
  // rd_ptr always sits on a group boundary, so a group never straddles the wrap.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= (r_wr_ptr == c_last_wr) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_rd_acc) begin
        r_rd_ptr <= (r_rd_ptr == c_last_rd) ? '0 : r_rd_ptr + c_scale_ptr;
      end
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_cnt <= r_cnt + CW'(1);
        2'b01:   r_cnt <= r_cnt - c_scale_cnt;
        2'b11:   r_cnt <= r_cnt + CW'(1) - c_scale_cnt;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Gather the READ_SCALE words of the group at rd_ptr, oldest in the LSBs.
  generate
    for (genvar k = 0; k < READ_SCALE; k++) begin : g_rd_lane
      assign w_group[k*WRITE_WIDTH +: WRITE_WIDTH] = r_mem[r_rd_ptr + AW'(k)];
    end
  endgenerate

  assign dout = w_empty ? '0 : w_group;

`ifdef COLLECT_FIFO_STATUS_EN
  logic r_overflow;
  logic r_underflow;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (wr_en && w_full) begin
        r_overflow <= 1'b1;
      end
      if (rd_en && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign overflow  = r_overflow;
  assign underflow = r_underflow;
  assign level     = r_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_util_collector_fifo.sv
// ============================================================================
//  Module   : tb_util_collector_fifo
//  Purpose  : Directed self-checking bench for util_collector_fifo with a
//             scoreboard queue of expected read words and a separate monitor.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_util_collector_fifo;

  localparam int WW = 32;
  localparam int RS = 2;
  localparam int DP = 16;
  localparam int DW = WW * RS;

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic          full;
  logic [WW-1:0] din;
  logic          rd_en;
  logic          empty;
  logic [DW-1:0] dout;
`ifdef COLLECT_FIFO_STATUS_EN
  logic          overflow;
  logic          underflow;
  logic [5:0]    level;
`endif

  util_collector_fifo #(
    .WRITE_WIDTH (WW),
    .READ_SCALE  (RS),
    .DEPTH       (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .wr_en (wr_en),
    .full  (full),
    .din   (din),
    .rd_en (rd_en),
    .empty (empty),
    .dout  (dout)
`ifdef COLLECT_FIFO_STATUS_EN
    ,
    .overflow  (overflow),
    .underflow (underflow),
    .level     (level)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [DW-1:0] sb [$];

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read will be accepted at the coming edge; compare the word now.
  always @(negedge clk) begin
    if (!rst_n && rd_en && !empty) begin
      n_checks++;
      if (sb.size() == 0) begin
        n_errors++;
        $display("FAIL sb_unexpected: got %h expected no read", dout);
      end else begin
        logic [DW-1:0] e;
        e = sb.pop_front();
        if (dout !== e) begin
          n_errors++;
          $display("FAIL sb_data: got %h expected %h", dout, e);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [WW-1:0] d);
    wr_en = 1'b1;
    din   = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [DW-1:0] exp);
    sb.push_back(exp);
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    repeat (2) step();

    // 1: reset state
    chk("rst_full", DW'(full), DW'(0));
    chk("rst_empty", DW'(empty), DW'(1));
    chk("rst_dout", dout, '0);
    rst_n = 1'b0;
    step();
    wr(32'h11);
    wr(32'h22);
    chk("pre_async_empty", DW'(empty), DW'(0));
    // asynchronous reset well away from the next rising edge
    @(negedge clk);
    #2 rst_n = 1'b1;
    #1;
    chk("async_rst_empty", DW'(empty), DW'(1));
    chk("async_rst_dout", dout, '0);
    step();
    rst_n = 1'b0;
    step();

    // 2: collect two words
    wr(32'd1234);
    chk("collect_empty1", DW'(empty), DW'(1));
    wr(32'h5678);
    chk("collect_empty2", DW'(empty), DW'(0));
    chk("collect_dout", dout, 64'h00005678_000004D2);
    rd(64'h00005678_000004D2);
    chk("collect_after_empty", DW'(empty), DW'(1));
    chk("collect_after_dout", dout, '0);

    // 3: partial word stays invisible
    wr(32'd1234);
    rd_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("partial_empty", DW'(empty), DW'(1));
      chk("partial_dout", dout, '0);
    end
    rd_en = 1'b0;
`ifdef COLLECT_FIFO_STATUS_EN
    chk("underflow_set", DW'(underflow), DW'(1));
    chk("level_partial", DW'(level), DW'(1));
`endif
    wr(32'hABCD);
    chk("partial_complete_dout", dout, 64'h0000ABCD_000004D2);
    rd(64'h0000ABCD_000004D2);

    // 4: fill to capacity, overflow write ignored
    for (int i = 0; i < 32; i++) begin
      chk("fill_full_low", DW'(full), DW'(0));
      wr(WW'(i));
    end
    chk("fill_full", DW'(full), DW'(1));
`ifdef COLLECT_FIFO_STATUS_EN
    chk("overflow_clear", DW'(overflow), DW'(0));
    chk("level_full", DW'(level), DW'(32));
`endif
    wr(32'hDEAD_BEEF);
    chk("fill_full_after_33", DW'(full), DW'(1));
`ifdef COLLECT_FIFO_STATUS_EN
    chk("overflow_set", DW'(overflow), DW'(1));
`endif
    for (int i = 0; i < 16; i++) begin
      rd({WW'(2 * i + 1), WW'(2 * i)});
    end
    chk("fill_drain_empty", DW'(empty), DW'(1));
    chk("fill_drain_full", DW'(full), DW'(0));
`ifdef COLLECT_FIFO_STATUS_EN
    chk("overflow_sticky", DW'(overflow), DW'(1));
    chk("underflow_sticky", DW'(underflow), DW'(1));
`endif

    // 5a: simultaneous write+read at cnt=2
    wr(32'hA0);
    wr(32'hA1);
    sb.push_back({32'hA1, 32'hA0});
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 32'hA2;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("simul_empty", DW'(empty), DW'(1));
`ifdef COLLECT_FIFO_STATUS_EN
    chk("simul_level", DW'(level), DW'(1));
`endif
    wr(32'hA3);
    chk("simul_dout", dout, {32'hA3, 32'hA2});
    rd({32'hA3, 32'hA2});

    // 5b: simultaneous at full: read accepted, write rejected
    for (int i = 0; i < 32; i++) wr(WW'(100 + i));
    chk("simul_full", DW'(full), DW'(1));
    sb.push_back({32'd101, 32'd100});
    wr_en = 1'b1;
    rd_en = 1'b1;
    din   = 32'd999;
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("simul_full_cleared", DW'(full), DW'(0));
`ifdef COLLECT_FIFO_STATUS_EN
    chk("simul_full_level", DW'(level), DW'(30));
`endif
    for (int i = 1; i < 16; i++) begin
      rd({WW'(100 + 2 * i + 1), WW'(100 + 2 * i)});
    end
    chk("simul_drain_empty", DW'(empty), DW'(1));

    // 6: sticky flags cleared by reset
    rst_n = 1'b1;
    step();
    rst_n = 1'b0;
    step();
`ifdef COLLECT_FIFO_STATUS_EN
    chk("overflow_rst", DW'(overflow), DW'(0));
    chk("underflow_rst", DW'(underflow), DW'(0));
    chk("level_rst", DW'(level), DW'(0));
`endif
    chk("final_empty", DW'(empty), DW'(1));
    chk("sb_leftover", DW'(sb.size()), DW'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Safety bound: the directed sequence is only a few hundred cycles long.
  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
